// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch controller: FSM states,
// command encoding with its fixed priority order, and parameter defaults.
package stopwatch_pkg;

  localparam int unsigned TICK_DIV_DEF        = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned CNT_W_DEF           = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE       = 2'd0,
    CMD_CLEAR      = 2'd1,
    CMD_START_STOP = 2'd2,
    CMD_LAP        = 2'd3
  } cmd_e;

  localparam int unsigned NUM_CMDS = 3;

  // Highest priority first; a lower-priority press in the same cycle is dropped.
  localparam cmd_e CMD_PRIORITY [NUM_CMDS] = '{CMD_CLEAR, CMD_START_STOP, CMD_LAP};

  // press[n] is the one-cycle press pulse for the command whose code is n.
  function automatic cmd_e encode_cmd(input logic [3:1] press);
    cmd_e cmd;
    cmd = CMD_NONE;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (press[CMD_PRIORITY[i]]) cmd = CMD_PRIORITY[i];
    end
    return cmd;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Link between the stopwatch controller and the counter/display datapath.
// The controller is the master: it sequences the counter and picks the display source.
interface stopwatch_ctrl_if import stopwatch_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic [CNT_W-1:0] count_value;
  logic [CNT_W-1:0] display_value;
  logic             tick_en;
  logic             count_clr;
  logic             running;
  logic             lap_active;

  modport master (
    input  count_value,
    output tick_en,
    output count_clr,
    output display_value,
    output running,
    output lap_active
  );

  modport slave (
    output count_value,
    input  tick_en,
    input  count_clr,
    input  display_value,
    input  running,
    input  lap_active
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One raw push-button to a clean one-cycle press pulse: 2-flop synchronizer,
// stable-level debounce counter, rising-edge detect on the accepted level.
module btn_debounce import stopwatch_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // NOTE: every flop here uses <= so all registers sample pre-edge values;
  // with = the synchronizer stages would collapse into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced button commands drive an IDLE/RUN/STOP/LAP FSM,
// a seconds prescaler producing tick_en, and the lap register for the display.
module stopwatch_ctrl import stopwatch_pkg::*; #(
  parameter int unsigned TICK_DIV        = TICK_DIV_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start_stop,
  input  logic             btn_lap,
  input  logic             btn_clear,
  stopwatch_ctrl_if.master bus
);

  localparam int unsigned   PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic press_start_stop;
  logic press_lap;
  logic press_clear;
  cmd_e cmd;

  state_e           state;
  state_e           state_nxt;
  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] lap_reg;
  logic             lap_hold;

  logic active;
  logic clr_cmd;
  logic presc_clr;
  logic lap_capture;
  logic lap_zero;
  logic hold_set;
  logic hold_clr;
  logic tick;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start_stop),
    .press (press_start_stop)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lap),
    .press (press_lap)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .press (press_clear)
  );

  assign cmd    = encode_cmd({press_lap, press_start_stop, press_clear});
  assign active = (state == ST_RUN) || (state == ST_LAP);

  // NOTE: every signal assigned below gets a default first, so no path
  // through the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    clr_cmd     = 1'b0;
    presc_clr   = 1'b0;
    lap_capture = 1'b0;
    lap_zero    = 1'b0;
    hold_set    = 1'b0;
    hold_clr    = 1'b0;

    if (cmd == CMD_CLEAR) begin
      clr_cmd   = 1'b1;
      presc_clr = 1'b1;
      hold_clr  = 1'b1;
      state_nxt = ST_IDLE;
      lap_zero  = (state == ST_STOP);
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd == CMD_START_STOP) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (cmd == CMD_START_STOP) begin
            state_nxt = ST_STOP;
          end else if (cmd == CMD_LAP) begin
            lap_capture = 1'b1;
            state_nxt   = ST_LAP;
          end
        end
        ST_LAP: begin
          // Stopping from LAP keeps the frozen lap value on the display.
          if (cmd == CMD_START_STOP) begin
            hold_set  = 1'b1;
            state_nxt = ST_STOP;
          end else if (cmd == CMD_LAP) begin
            hold_clr  = 1'b1;
            state_nxt = ST_RUN;
          end
        end
        ST_STOP: begin
          if (cmd == CMD_START_STOP) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign tick = active && (presc == PRESC_MAX) && !clr_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      presc    <= '0;
      lap_reg  <= '0;
      lap_hold <= 1'b0;
    end else begin
      state <= state_nxt;

      // Prescaler holds outside RUN/LAP so a pause keeps the partial second.
      if (presc_clr) begin
        presc <= '0;
      end else if (active) begin
        presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
      end

      if (lap_zero) begin
        lap_reg <= '0;
      end else if (lap_capture) begin
        lap_reg <= bus.count_value;
      end

      if (hold_clr) begin
        lap_hold <= 1'b0;
      end else if (hold_set) begin
        lap_hold <= 1'b1;
      end
    end
  end

  assign bus.tick_en       = tick;
  assign bus.count_clr     = clr_cmd;
  assign bus.running       = active;
  assign bus.lap_active    = (state == ST_LAP);
  assign bus.display_value = ((state == ST_LAP) || lap_hold) ? lap_reg : bus.count_value;

endmodule
